llc_input_scheduler: RTL and testbench

//  Front-end scheduler for the LLC input decode stage. Arbitrates each cycle between

---
 rtl/llc_input_scheduler_if.sv | 26 ++
 rtl/llc_input_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_llc_input_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/llc_input_scheduler_if.sv
// Handshake bundle between the LLC input sources, the scheduler and the decode/lookup pipeline.
// master = source/pipeline side, slave = scheduler side.
interface llc_input_scheduler_if #(
    parameter int LINE_ADDR_W = 26
);
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [LINE_ADDR_W-1:0] rsp_addr;
    logic                   req_valid;
    logic                   req_ready;
    logic [LINE_ADDR_W-1:0] req_addr;
    logic                   grant_valid;
    logic                   grant_ready;
    logic [1:0]             grant_src;
    logic [LINE_ADDR_W-1:0] grant_addr;

    modport master (
        output rsp_valid, rsp_addr, req_valid, req_addr, grant_ready,
        input  rsp_ready, req_ready, grant_valid, grant_src, grant_addr
    );

    modport slave (
        input  rsp_valid, rsp_addr, req_valid, req_addr, grant_ready,
        output rsp_ready, req_ready, grant_valid, grant_src, grant_addr
    );
endinterface

// File: rtl/llc_input_scheduler.sv
// LLC input scheduler: rsp > replay > req arbitration with MSHR credits, set-conflict replay FIFO
// and anti-starvation. Optional per-source grant counters when LLC_SCHED_STATS_EN is defined.
module llc_input_scheduler #(
    parameter int N_MSHR       = 16,
    parameter int REPLAY_DEPTH = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int LINE_ADDR_W  = 26
) (
    input  logic                           clk,
    input  logic                           rst,
    llc_input_scheduler_if.slave           bus,
    input  logic                           evict_stall,
    input  logic                           mshr_free,
    input  logic                           conflict,
    input  logic [LINE_ADDR_W-1:0]         conflict_addr,
    output logic [$clog2(N_MSHR+1)-1:0]    mshr_avail,
    output logic                           replay_full
`ifdef LLC_SCHED_STATS_EN
    ,
    output logic [31:0]                    stat_rsp,
    output logic [31:0]                    stat_req,
    output logic [31:0]                    stat_replay,
    output logic [31:0]                    stat_starve
`endif
);
    localparam int CW    = $clog2(N_MSHR + 1);
    localparam int PTR_W = $clog2(REPLAY_DEPTH);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, GRANT} state_t;
    state_t state_reg, state_next;

    logic [CW-1:0]          mshr_avail_reg;
    logic [CW:0]            credit_sum;
    logic [SW-1:0]          starve_cnt_reg;
    logic [1:0]             grant_src_reg;
    logic [LINE_ADDR_W-1:0] grant_addr_reg;

    logic [LINE_ADDR_W-1:0] fifo_mem [REPLAY_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_reg, wr_ptr_reg;
    logic [PTR_W:0]         count_reg;
    logic                   fifo_empty, push_ok;

    logic load, starved, credit_ok;
    logic rsp_elig, rep_elig, req_elig;
    logic win_rsp, win_rep, win_req, any_win, take;

    assign fifo_empty  = (count_reg == '0);
    assign replay_full = (count_reg == (PTR_W+1)'(REPLAY_DEPTH));
    assign credit_ok   = (mshr_avail_reg != '0);
    assign starved     = (starve_cnt_reg == SW'(STARVE_LIMIT));
    assign load        = (state_reg == IDLE) || bus.grant_ready;

    assign rsp_elig = bus.rsp_valid;
    assign rep_elig = !fifo_empty && credit_ok && !evict_stall;
    assign req_elig = bus.req_valid && credit_ok && !evict_stall && !replay_full;

    always_comb begin
        win_rsp = 1'b0;
        win_rep = 1'b0;
        win_req = 1'b0;
        if (load) begin
            if (starved && (rep_elig || req_elig)) begin
                win_rep = rep_elig;
                win_req = !rep_elig;
            end else if (rsp_elig) begin
                win_rsp = 1'b1;
            end else if (rep_elig) begin
                win_rep = 1'b1;
            end else begin
                win_req = req_elig;
            end
        end
    end

    assign take    = win_rep || win_req;
    assign any_win = win_rsp || take;

    // FSM: state register / next state / outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_win) state_next = GRANT;
            GRANT:   if (bus.grant_ready) state_next = any_win ? GRANT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.grant_valid = (state_reg == GRANT);
        bus.rsp_ready   = win_rsp;
        bus.req_ready   = win_req;
        bus.grant_src   = grant_src_reg;
        bus.grant_addr  = grant_addr_reg;
        mshr_avail      = mshr_avail_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_src_reg  <= 2'd0;
            grant_addr_reg <= '0;
        end else if (any_win) begin
            grant_src_reg  <= win_rsp ? 2'd0 : (win_req ? 2'd1 : 2'd2);
            grant_addr_reg <= win_rsp ? bus.rsp_addr :
                              (win_req ? bus.req_addr : fifo_mem[rd_ptr_reg]);
        end
    end

    // Starvation only counts rsp wins that actually pushed a ready replay/req aside
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_reg <= '0;
        end else if (take) begin
            starve_cnt_reg <= '0;
        end else if (win_rsp && (rep_elig || req_elig) && !starved) begin
            starve_cnt_reg <= starve_cnt_reg + SW'(1);
        end
    end

    // A conflict cancels the allocation made at grant time, so it returns a credit
    assign credit_sum = {1'b0, mshr_avail_reg} + (CW+1)'(mshr_free) + (CW+1)'(conflict)
                        - (CW+1)'(take);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mshr_avail_reg <= CW'(N_MSHR);
        else if (credit_sum > (CW+1)'(N_MSHR))
            mshr_avail_reg <= CW'(N_MSHR);
        else
            mshr_avail_reg <= credit_sum[CW-1:0];
    end

    assign push_ok = conflict && (!replay_full || win_rep);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_reg] <= conflict_addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (win_rep) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + (PTR_W+1)'(push_ok) - (PTR_W+1)'(win_rep);
        end
    end

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
        credit_sum <= (CW+1)'(N_MSHR));
    a_replay_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(conflict && replay_full && !win_rep));

`ifdef LLC_SCHED_STATS_EN
    logic [3:0]  stat_inc;
    logic [31:0] stat_cnt_reg [4];

    assign stat_inc = {starved && rsp_elig && take, win_rep, win_req, win_rsp};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stat
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)              stat_cnt_reg[gi] <= '0;
                else if (stat_inc[gi]) stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 32'd1;
            end
        end
    endgenerate

    assign stat_rsp    = stat_cnt_reg[0];
    assign stat_req    = stat_cnt_reg[1];
    assign stat_replay = stat_cnt_reg[2];
    assign stat_starve = stat_cnt_reg[3];
`endif
endmodule

// File: tb/tb_llc_input_scheduler.sv
// Directed bench for llc_input_scheduler: reset, single req, starvation pattern, credits,
// replay ordering, grant hold and mid-operation reset.
module tb_llc_input_scheduler;
    localparam int LW = 26;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          evict_stall, mshr_free, conflict;
    logic [LW-1:0] conflict_addr;
    logic [4:0]    mshr_avail;
    logic          replay_full;
`ifdef LLC_SCHED_STATS_EN
    logic [31:0]   stat_rsp, stat_req, stat_replay, stat_starve;
`endif

    int checks   = 0;
    int failures = 0;

    llc_input_scheduler_if #(.LINE_ADDR_W(LW)) bus ();

    llc_input_scheduler #(
        .N_MSHR(16), .REPLAY_DEPTH(4), .STARVE_LIMIT(8), .LINE_ADDR_W(LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .evict_stall   (evict_stall),
        .mshr_free     (mshr_free),
        .conflict      (conflict),
        .conflict_addr (conflict_addr),
        .mshr_avail    (mshr_avail),
        .replay_full   (replay_full)
`ifdef LLC_SCHED_STATS_EN
        ,
        .stat_rsp      (stat_rsp),
        .stat_req      (stat_req),
        .stat_replay   (stat_replay),
        .stat_starve   (stat_starve)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.rsp_valid   = 1'b0;
        bus.rsp_addr    = '0;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.grant_ready = 1'b0;
        evict_stall     = 1'b0;
        mshr_free       = 1'b0;
        conflict        = 1'b0;
        conflict_addr   = '0;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // reset, idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_gv", 32'(bus.grant_valid), 32'd0);
            chk("idle_avail", 32'(mshr_avail), 32'd16);
            chk("idle_full", 32'(replay_full), 32'd0);
        end

        // single request
        bus.req_addr    = LW'(26'h123);
        bus.req_valid   = 1'b1;
        bus.grant_ready = 1'b1;
        #1 chk("req1_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk("req1_gv", 32'(bus.grant_valid), 32'd1);
        chk("req1_src", 32'(bus.grant_src), 32'd1);
        chk("req1_addr", 32'(bus.grant_addr), 32'h123);
        chk("req1_avail", 32'(mshr_avail), 32'd15);
        chk("req1_ready_low", 32'(bus.req_ready), 32'd0);
        tick();
        chk("req1_idle", 32'(bus.grant_valid), 32'd0);

        // starvation: 8 rsp then 1 req, repeating
        do_reset();
        bus.rsp_addr    = LW'(26'h0AA);
        bus.req_addr    = LW'(26'h0BB);
        bus.rsp_valid   = 1'b1;
        bus.req_valid   = 1'b1;
        bus.grant_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            chk($sformatf("starve_rsp_rdy[%0d]", i), 32'(bus.rsp_ready), (i % 9 != 8) ? 32'd1 : 32'd0);
            chk($sformatf("starve_req_rdy[%0d]", i), 32'(bus.req_ready), (i % 9 == 8) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("starve_src[%0d]", i), 32'(bus.grant_src), (i % 9 == 8) ? 32'd1 : 32'd0);
        end
        chk("starve_avail", 32'(mshr_avail), 32'd14);

        // credit exhaustion and single release
        do_reset();
        bus.req_addr    = LW'(26'h200);
        bus.req_valid   = 1'b1;
        bus.grant_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1 chk($sformatf("cred_rdy[%0d]", i), 32'(bus.req_ready), 32'd1);
            tick();
        end
        chk("cred_avail0", 32'(mshr_avail), 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("cred_block[%0d]", i), 32'(bus.req_ready), 32'd0);
            tick();
        end
        mshr_free = 1'b1;
        #1 chk("cred_free_cycle_rdy", 32'(bus.req_ready), 32'd0);
        tick();
        mshr_free = 1'b0;
        #1;
        chk("cred_avail1", 32'(mshr_avail), 32'd1);
        chk("cred_regrant_rdy", 32'(bus.req_ready), 32'd1);
        tick();
        chk("cred_avail_back0", 32'(mshr_avail), 32'd0);
        #1 chk("cred_block_again", 32'(bus.req_ready), 32'd0);

        // reset mid-operation restores credits and drops the grant
        bus.grant_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_gv", 32'(bus.grant_valid), 32'd0);
        chk("midrst_avail", 32'(mshr_avail), 32'd16);

        // replay FIFO fill, req blocked, FIFO order
        do_reset();
        bus.req_addr    = LW'(26'h300);
        bus.req_valid   = 1'b1;
        bus.grant_ready = 1'b1;
        repeat (4) tick();
        bus.req_valid = 1'b0;
        chk("rep_pre_avail", 32'(mshr_avail), 32'd12);
        evict_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            conflict      = 1'b1;
            conflict_addr = LW'(32'h10 + 32'(i));
            tick();
        end
        conflict = 1'b0;
        chk("rep_full", 32'(replay_full), 32'd1);
        chk("rep_avail16", 32'(mshr_avail), 32'd16);
        evict_stall   = 1'b0;
        bus.req_addr  = LW'(26'h077);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("rep_req_blk[%0d]", i), 32'(bus.req_ready), 32'd0);
            tick();
            chk($sformatf("rep_src[%0d]", i), 32'(bus.grant_src), 32'd2);
            chk($sformatf("rep_addr[%0d]", i), 32'(bus.grant_addr), 32'h10 + 32'(i));
        end
        chk("rep_avail12", 32'(mshr_avail), 32'd12);
        chk("rep_empty_notfull", 32'(replay_full), 32'd0);
        #1 chk("rep_req_after", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("rep_req_src", 32'(bus.grant_src), 32'd1);
        chk("rep_req_addr", 32'(bus.grant_addr), 32'h077);
        chk("rep_req_avail", 32'(mshr_avail), 32'd11);

        // grant held while pipeline stalls
        do_reset();
        bus.rsp_addr  = LW'(26'h055);
        bus.rsp_valid = 1'b1;
        #1 chk("hold_first_rdy", 32'(bus.rsp_ready), 32'd1);
        tick();
        bus.rsp_addr = LW'(26'h066);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("hold_rdy[%0d]", i), 32'(bus.rsp_ready), 32'd0);
            chk($sformatf("hold_addr[%0d]", i), 32'(bus.grant_addr), 32'h055);
            chk($sformatf("hold_gv[%0d]", i), 32'(bus.grant_valid), 32'd1);
            tick();
        end
        bus.grant_ready = 1'b1;
        #1 chk("hold_release_rdy", 32'(bus.rsp_ready), 32'd1);
        tick();
        chk("hold_new_addr", 32'(bus.grant_addr), 32'h066);
        chk("hold_new_src", 32'(bus.grant_src), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
